// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 data mux among four requesters, with a
// valid/ready output port and a per-grant burst limit.
module mux4_rr_arbiter #(
    parameter int unsigned W         = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   req,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    input  logic [W-1:0] d3,
    output logic [3:0]   ack,
    output logic [3:0]   grant,
    output logic [1:0]   sel,
    output logic         y_valid,
    output logic [W-1:0] y_data,
    input  logic         y_ready
);

    localparam int unsigned CntW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CntW-1:0] LastBeat = CntW'(MAX_BURST - 1);

    typedef enum logic {StIdle, StBusy} state_e;

    state_e          state_q, state_d;
    logic [3:0]      grant_q, grant_d;
    logic [1:0]      sel_q, sel_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [CntW-1:0] beat_cnt_q, beat_cnt_d;

    logic       xfer;
    logic       pick_found;
    logic [1:0] pick_idx;
    logic [1:0] cand_idx;

    // Scan from ptr upward; iterating downward lets the nearest candidate win.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = ptr_q;
        cand_idx   = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            cand_idx = ptr_q + 2'(k);
            if (req[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        y_data = d0;
        case (sel_q)
            2'd0: y_data = d0;
            2'd1: y_data = d1;
            2'd2: y_data = d2;
            2'd3: y_data = d3;
            default: y_data = d0;
        endcase
    end

    assign y_valid = (state_q == StBusy) && req[sel_q];
    assign xfer    = y_valid && y_ready;
    assign ack     = xfer ? (4'(1) << sel_q) : 4'b0000;
    assign grant   = grant_q;
    assign sel     = sel_q;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        sel_d      = sel_q;
        ptr_d      = ptr_q;
        beat_cnt_d = beat_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    state_d    = StBusy;
                    sel_d      = pick_idx;
                    grant_d    = 4'(1) << pick_idx;
                    beat_cnt_d = '0;
                end
            end
            StBusy: begin
                // Owner withdrawing or finishing its last allowed beat both hand over.
                if (!req[sel_q] || (xfer && (beat_cnt_q == LastBeat))) begin
                    state_d    = StIdle;
                    grant_d    = 4'b0000;
                    ptr_d      = sel_q + 2'd1;
                    beat_cnt_d = '0;
                end else if (xfer) begin
                    beat_cnt_d = beat_cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            grant_q    <= 4'b0000;
            sel_q      <= 2'd0;
            ptr_q      <= 2'd0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            sel_q      <= sel_d;
            ptr_q      <= ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed vector table, hand-written
// corner sequences and random traffic checked against a behavioural model.
module tb_mux4_rr_arbiter;

    localparam int W         = 8;
    localparam int MAX_BURST = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req;
    logic [W-1:0] d [4];
    logic [3:0]   ack;
    logic [3:0]   grant;
    logic [1:0]   sel;
    logic         y_valid;
    logic [W-1:0] y_data;
    logic         y_ready;

    mux4_rr_arbiter #(
        .W        (W),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .d0     (d[0]),
        .d1     (d[1]),
        .d2     (d[2]),
        .d3     (d[3]),
        .ack    (ack),
        .grant  (grant),
        .sel    (sel),
        .y_valid(y_valid),
        .y_data (y_data),
        .y_ready(y_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: who owns the port, whose turn is next, beats so far.
    bit m_busy;
    int m_owner;
    int m_next;
    int m_beats;
    int m_sel;

    function automatic void model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_next  = 0;
        m_beats = 0;
        m_sel   = 0;
    endfunction

    function automatic void model_step();
        if (!m_busy) begin
            for (int k = 0; k < 4; k++) begin
                int i;
                i = (m_next + k) % 4;
                if (req[i]) begin
                    m_busy  = 1'b1;
                    m_owner = i;
                    m_sel   = i;
                    m_beats = 0;
                    break;
                end
            end
        end else if (!req[m_owner]) begin
            m_busy = 1'b0;
            m_next = (m_owner + 1) % 4;
        end else if (y_ready) begin
            m_beats++;
            if (m_beats == MAX_BURST) begin
                m_busy = 1'b0;
                m_next = (m_owner + 1) % 4;
            end
        end
    endfunction

    task automatic check_model();
        logic [3:0] e_grant;
        logic       e_valid;
        logic [3:0] e_ack;
        e_grant = m_busy ? 4'(1 << m_owner) : 4'b0000;
        e_valid = m_busy && req[m_owner];
        e_ack   = (e_valid && y_ready) ? 4'(1 << m_owner) : 4'b0000;
        chk("model_grant", grant, e_grant);
        chk("model_sel", sel, m_sel);
        chk("model_valid", y_valid, e_valid);
        chk("model_ack", ack, e_ack);
        chk("model_data", y_data, d[m_sel]);
    endtask

    logic [3:0] s_grant;
    logic [3:0] s_ack;

    // Inputs are set at posedge+1; outputs checked at negedge; model advances at the edge.
    task automatic cycle();
        @(negedge clk);
        s_grant = grant;
        s_ack   = ack;
        check_model();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string name);
        rst_n = 1'b0;
        #1;
        chk({name, "_grant"}, grant, 4'b0000);
        chk({name, "_ack"}, ack, 4'b0000);
        chk({name, "_valid"}, y_valid, 1'b0);
        chk({name, "_sel"}, sel, 2'd0);
        chk({name, "_data"}, y_data, d[0]);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    function automatic int onehot_idx(input logic [3:0] g);
        case (g)
            4'b0001: return 0;
            4'b0010: return 1;
            4'b0100: return 2;
            4'b1000: return 3;
            default: return -1;
        endcase
    endfunction

    typedef struct packed {
        logic [3:0] req;
        logic       rdy;
        logic [3:0] grant;
        logic [1:0] sel;
        logic       valid;
        logic [3:0] ack;
    } vec_t;

    vec_t tbl [14];

    initial begin
        int order[$];
        int acks[$];
        logic [3:0] prev;

        // Single requester 2 then backpressured requester 1, from a fresh reset.
        tbl[0]  = '{4'b0100, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0000};
        tbl[1]  = '{4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 4'b0100};
        tbl[2]  = '{4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 4'b0100};
        tbl[3]  = '{4'b0000, 1'b1, 4'b0100, 2'd2, 1'b0, 4'b0000};
        tbl[4]  = '{4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0, 4'b0000};
        tbl[5]  = '{4'b0010, 1'b0, 4'b0000, 2'd2, 1'b0, 4'b0000};
        for (int i = 6; i <= 10; i++) tbl[i] = '{4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 4'b0000};
        tbl[11] = '{4'b0010, 1'b1, 4'b0010, 2'd1, 1'b1, 4'b0010};
        tbl[12] = '{4'b0000, 1'b1, 4'b0010, 2'd1, 1'b0, 4'b0000};
        tbl[13] = '{4'b0000, 1'b1, 4'b0000, 2'd1, 1'b0, 4'b0000};

        d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'hA5; d[3] = 8'h44;
        req = 4'hF;
        y_ready = 1'b1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset with all requests up; first arbitration must pick requester 0.
        do_reset("reset");
        cycle();
        cycle();
        chk("reset_first_grant", s_grant, 4'b0001);

        // Vector table.
        req = 4'b0000;
        do_reset("reset_tbl");
        for (int i = 0; i < 14; i++) begin
            req     = tbl[i].req;
            y_ready = tbl[i].rdy;
            @(negedge clk);
            chk($sformatf("tbl%0d_grant", i), grant, tbl[i].grant);
            chk($sformatf("tbl%0d_sel", i), sel, tbl[i].sel);
            chk($sformatf("tbl%0d_valid", i), y_valid, tbl[i].valid);
            chk($sformatf("tbl%0d_ack", i), ack, tbl[i].ack);
            chk($sformatf("tbl%0d_data", i), y_data, d[tbl[i].sel]);
            @(posedge clk);
            #1;
        end

        // Round-robin with every requester busy: 0,1,2,3,0 with full bursts.
        req = 4'hF;
        y_ready = 1'b1;
        do_reset("reset_rr");
        prev = 4'b0000;
        for (int c = 0; c < 25; c++) begin
            cycle();
            if (s_grant != 4'b0000 && prev == 4'b0000) begin
                order.push_back(onehot_idx(s_grant));
                acks.push_back(0);
            end
            if (s_ack != 4'b0000 && acks.size() > 0) acks[acks.size() - 1]++;
            prev = s_grant;
        end
        chk("rr_grant_count", order.size(), 5);
        for (int i = 0; i < order.size() && i < 5; i++)
            chk($sformatf("rr_order%0d", i), order[i], i % 4);
        for (int i = 0; i < acks.size() && i < 4; i++)
            chk($sformatf("rr_acks%0d", i), acks[i], MAX_BURST);

        // Early release: owner 3 drops after two beats, pending 0 takes over.
        req = 4'b1000;
        do_reset("reset_early");
        cycle();
        req = 4'b1001;
        cycle();
        chk("early_ack1", s_ack, 4'b1000);
        cycle();
        chk("early_ack2", s_ack, 4'b1000);
        req = 4'b0001;
        cycle();
        chk("early_drop_grant", s_grant, 4'b1000);
        chk("early_drop_ack", s_ack, 4'b0000);
        cycle();
        chk("early_bubble", s_grant, 4'b0000);
        cycle();
        chk("early_next", s_grant, 4'b0001);

        // Reset in the middle of a burst owned by requester 2.
        req = 4'b0100;
        do_reset("reset_pre_mid");
        cycle();
        cycle();
        chk("mid_owner", s_grant, 4'b0100);
        chk("mid_ack", s_ack, 4'b0100);
        req = 4'hF;
        do_reset("reset_mid");
        cycle();
        cycle();
        chk("mid_restart", s_grant, 4'b0001);

        // Random traffic against the model, with one reset part way through.
        req = 4'b0000;
        do_reset("reset_rand");
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0) req[$urandom_range(0, 3)] ^= 1'b1;
            for (int i = 0; i < 4; i++) d[i] = W'($urandom);
            y_ready = ($urandom_range(0, 3) != 0);
            if (c == 700) do_reset("reset_rand_mid");
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
